// File: rtl/regfile_op_sequencer.sv
// Four-phase register-file operation sequencer: accepts one op, reads two sources,
// executes an 8-bit ALU op and writes the destination back, pulsing done.
module regfile_op_sequencer #(
    parameter bit ZERO_REG_PROTECT = 1'b0
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [3:0] op_src1,
    input  logic [3:0] op_src2,
    input  logic [3:0] op_dst,
    output logic       RegFileRead,
    output logic       RegFileWrite,
    output logic [3:0] Source1,
    output logic [3:0] Source2,
    output logic [3:0] Destin,
    output logic [7:0] Datain,
    input  logic [7:0] Dataout1,
    input  logic [7:0] Dataout2,
    output logic       done,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    state_t     state_r;
    state_t     state_next_s;
    logic [2:0] op_code_r;
    logic [3:0] src1_r;
    logic [3:0] src2_r;
    logic [3:0] dst_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] result_r;
    logic       carry_r;
    logic       zero_r;
    logic [8:0] alu_s;
    logic       accept_s;
    logic       write_en_s;

    // Bit 8 carries the ADD carry-out or the SUB borrow; it is 0 for every other op.
    function automatic logic [8:0] alu_calc(input logic [2:0] code,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] res;
        case (code)
            OP_MOV:  res = {1'b0, a};
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_XOR:  res = {1'b0, a ^ b};
            OP_NOT:  res = {1'b0, ~a};
            default: res = 9'd0;
        endcase
        return res;
    endfunction

    assign alu_s      = alu_calc(op_code_r, a_r, b_r);
    assign accept_s   = op_valid && op_ready;
    assign write_en_s = (op_code_r != OP_NOP) && !(ZERO_REG_PROTECT && (dst_r == 4'd0));

    // State register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: only the IDLE exit waits on a handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ:  state_next_s = ST_EXEC;
            ST_EXEC:  state_next_s = ST_WRITE;
            ST_WRITE: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output decode; Reset masks every strobe so an abandoned op never writes
    always_comb begin
        op_ready     = 1'b0;
        RegFileRead  = 1'b0;
        RegFileWrite = 1'b0;
        done         = 1'b0;
        Datain       = 8'h00;
        if (!Reset) begin
            case (state_r)
                ST_IDLE:  op_ready = 1'b1;
                ST_READ:  RegFileRead = 1'b1;
                ST_EXEC:  op_ready = 1'b0;
                ST_WRITE: begin
                    RegFileWrite = write_en_s;
                    done         = 1'b1;
                    Datain       = result_r;
                end
                default:  op_ready = 1'b0;
            endcase
        end else begin
            op_ready = 1'b0;
        end
    end

    // Operation capture, operand capture and result/flag update
    always_ff @(posedge clk) begin
        if (Reset) begin
            op_code_r <= 3'd0;
            src1_r    <= 4'd0;
            src2_r    <= 4'd0;
            dst_r     <= 4'd0;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            result_r  <= 8'h00;
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                op_code_r <= op_code;
                src1_r    <= op_src1;
                src2_r    <= op_src2;
                dst_r     <= op_dst;
            end
            if (state_r == ST_READ) begin
                a_r <= Dataout1;
                b_r <= Dataout2;
            end
            // New result becomes visible in the WRITE cycle; NOP leaves it untouched
            if ((state_r == ST_EXEC) && (op_code_r != OP_NOP)) begin
                result_r <= alu_s[7:0];
                carry_r  <= alu_s[8];
                zero_r   <= (alu_s[7:0] == 8'h00);
            end
        end
    end

    assign Source1 = src1_r;
    assign Source2 = src2_r;
    assign Destin  = dst_r;
    assign result  = result_r;
    assign carry   = carry_r;
    assign zero    = zero_r;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench: two sequencers (R0 protect off / on) share stimulus; a reference
// model predicts each op at accept time and a monitor checks it when done pulses.
module tb_regfile_op_sequencer;

    typedef struct {
        int              done_cyc;
        logic [3:0]      s1;
        logic [3:0]      s2;
        logic [3:0]      dst;
        logic [1:0]      we;
        logic [1:0][7:0] res;
        logic [1:0]      car;
        logic [1:0]      zr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset;
    logic       op_valid;
    logic [2:0] op_code;
    logic [3:0] op_src1, op_src2, op_dst;
    logic [1:0] op_ready, rd, wr, done, carry, zero;
    logic [3:0] s1 [2];
    logic [3:0] s2 [2];
    logic [3:0] dst [2];
    logic [7:0] din [2];
    logic [7:0] dout1 [2];
    logic [7:0] dout2 [2];
    logic [7:0] result [2];
    logic [7:0] rf [2][16];
    logic       pl_en;
    logic [3:0] pl_idx;
    logic [7:0] pl_data;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         next_free = 0;
    logic [7:0] mrf [2][16];
    logic [7:0] mres [2];
    logic       mcar [2];
    logic       mzr [2];
    exp_t       sb [$];

    regfile_op_sequencer #(.ZERO_REG_PROTECT(1'b0)) dut0 (
        .clk(clk), .Reset(Reset), .op_valid(op_valid), .op_ready(op_ready[0]),
        .op_code(op_code), .op_src1(op_src1), .op_src2(op_src2), .op_dst(op_dst),
        .RegFileRead(rd[0]), .RegFileWrite(wr[0]), .Source1(s1[0]), .Source2(s2[0]),
        .Destin(dst[0]), .Datain(din[0]), .Dataout1(dout1[0]), .Dataout2(dout2[0]),
        .done(done[0]), .result(result[0]), .carry(carry[0]), .zero(zero[0])
    );

    regfile_op_sequencer #(.ZERO_REG_PROTECT(1'b1)) dut1 (
        .clk(clk), .Reset(Reset), .op_valid(op_valid), .op_ready(op_ready[1]),
        .op_code(op_code), .op_src1(op_src1), .op_src2(op_src2), .op_dst(op_dst),
        .RegFileRead(rd[1]), .RegFileWrite(wr[1]), .Source1(s1[1]), .Source2(s2[1]),
        .Destin(dst[1]), .Datain(din[1]), .Dataout1(dout1[1]), .Dataout2(dout2[1]),
        .done(done[1]), .result(result[1]), .carry(carry[1]), .zero(zero[1])
    );

    assign dout1[0] = rf[0][s1[0]];
    assign dout2[0] = rf[0][s2[0]];
    assign dout1[1] = rf[1][s1[1]];
    assign dout2[1] = rf[1][s2[1]];

    // Bench-side register files: preload port has priority over DUT writes
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (pl_en) rf[i][pl_idx] <= pl_data;
            else if (wr[i]) rf[i][dst[i]] <= din[i];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU in plain integer arithmetic
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output int c);
        c = 0;
        case (op)
            0: r = a;
            1: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            2: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = 255 - a;
            default: r = 0;
        endcase
    endfunction

    // Model side: predicts readiness and pushes the expected outcome of every accepted op
    always @(negedge clk) begin : model_push
        exp_t e;
        int   a, b, r, c;
        if (Reset) begin
            for (int i = 0; i < 2; i++) chk("ready_in_reset", int'(op_ready[i]), 0);
            next_free = cyc + 1;
        end else begin
            for (int i = 0; i < 2; i++) chk("op_ready", int'(op_ready[i]), (cyc >= next_free) ? 1 : 0);
            if (op_valid && (cyc >= next_free)) begin
                e.done_cyc = cyc + 3;
                e.s1  = op_src1;
                e.s2  = op_src2;
                e.dst = op_dst;
                for (int i = 0; i < 2; i++) begin
                    a = int'(mrf[i][op_src1]);
                    b = int'(mrf[i][op_src2]);
                    ref_alu(int'(op_code), a, b, r, c);
                    if (op_code == 3'd7) begin
                        e.res[i] = mres[i];
                        e.car[i] = mcar[i];
                        e.zr[i]  = mzr[i];
                        e.we[i]  = 1'b0;
                    end else begin
                        e.res[i] = r[7:0];
                        e.car[i] = c[0];
                        e.zr[i]  = (r == 0);
                        e.we[i]  = !((i == 1) && (op_dst == 4'd0));
                    end
                end
                sb.push_back(e);
                next_free = cyc + 4;
            end
        end
    end

    // Monitor: compares strobes, buses and flags against the scoreboard head
    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_done, exp_rd, exp_wr;
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                chk("read_in_reset", int'(rd[i]), 0);
                chk("write_in_reset", int'(wr[i]), 0);
                chk("done_in_reset", int'(done[i]), 0);
                mres[i] = 8'h00;
                mcar[i] = 1'b0;
                mzr[i]  = 1'b0;
            end
            sb.delete();
        end else begin
            exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
            exp_rd   = (sb.size() > 0) && (sb[0].done_cyc == cyc + 2);
            if (sb.size() > 0) e = sb[0];
            for (int i = 0; i < 2; i++) begin
                exp_wr = exp_done && e.we[i];
                if (rd[i] || exp_rd) begin
                    chk("read_strobe", int'(rd[i]), int'(exp_rd));
                    if (exp_rd) begin
                        chk("source1", int'(s1[i]), int'(e.s1));
                        chk("source2", int'(s2[i]), int'(e.s2));
                    end
                end
                if (done[i] || exp_done) chk("done", int'(done[i]), int'(exp_done));
                if (wr[i] || exp_wr) chk("write_strobe", int'(wr[i]), int'(exp_wr));
                if (exp_done) begin
                    chk("destin", int'(dst[i]), int'(e.dst));
                    chk("datain", int'(din[i]), int'(e.res[i]));
                    chk("result", int'(result[i]), int'(e.res[i]));
                    chk("carry", int'(carry[i]), int'(e.car[i]));
                    chk("zero", int'(zero[i]), int'(e.zr[i]));
                    if (e.we[i]) mrf[i][e.dst] = e.res[i];
                    mres[i] = e.res[i];
                    mcar[i] = e.car[i];
                    mzr[i]  = e.zr[i];
                end else if (din[i] != 8'h00) begin
                    chk("datain_outside_write", int'(din[i]), 0);
                end
            end
            if (exp_done) void'(sb.pop_front());
        end
    end

    task automatic preload(input int idx, input int val);
        @(posedge clk); #1;
        pl_en   = 1'b1;
        pl_idx  = idx[3:0];
        pl_data = val[7:0];
        for (int i = 0; i < 2; i++) mrf[i][idx] = val[7:0];
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Presents one op, waits (bounded) for its accept, returns early in the READ cycle
    task automatic issue(input int op, input int a, input int b, input int d);
        bit got;
        @(posedge clk); #1;
        op_valid = 1'b1;
        op_code  = op[2:0];
        op_src1  = a[3:0];
        op_src2  = b[3:0];
        op_dst   = d[3:0];
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = op_ready[0];
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] acc;
        logic [7:0]  keep;
        Reset = 1'b1; op_valid = 1'b0; op_code = 3'd0;
        op_src1 = 4'd0; op_src2 = 4'd0; op_dst = 4'd0;
        pl_en = 1'b0; pl_idx = 4'd0; pl_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_result", int'(result[i]), 0);
            chk("reset_carry", int'(carry[i]), 0);
            chk("reset_zero", int'(zero[i]), 0);
            chk("reset_source1", int'(s1[i]), 0);
            chk("reset_destin", int'(dst[i]), 0);
            chk("reset_datain", int'(din[i]), 0);
        end
        for (int r = 0; r < 16; r++) preload(r, int'($urandom_range(0, 255)));
        @(posedge clk); #1;
        Reset = 1'b0;

        // ADD with carry-out, then NOP must leave flags and result alone
        preload(1, 8'hF0); preload(2, 8'h20);
        issue(1, 1, 2, 3); settle();
        chk("add_rf_r3", int'(rf[0][3]), 8'h10);
        chk("add_carry", int'(carry[0]), 1);
        chk("add_zero", int'(zero[0]), 0);
        keep = rf[0][5];
        issue(7, 0, 0, 5); settle();
        chk("nop_carry_held", int'(carry[0]), 1);
        chk("nop_result_held", int'(result[0]), 8'h10);
        chk("nop_no_write", int'(rf[0][5]), int'(keep));

        // SUB equal operands, then SUB with borrow
        preload(4, 8'h05); preload(5, 8'h05);
        issue(2, 4, 5, 6); settle();
        chk("sub_eq_result", int'(result[0]), 0);
        chk("sub_eq_zero", int'(zero[0]), 1);
        chk("sub_eq_carry", int'(carry[0]), 0);
        preload(4, 8'h03);
        issue(2, 4, 5, 6); settle();
        chk("sub_borrow_rf_r6", int'(rf[0][6]), 8'hFE);
        chk("sub_borrow_carry", int'(carry[0]), 1);

        // MOV into R0: written without protect, suppressed with protect
        preload(0, 8'hAA); preload(7, 8'h55);
        issue(0, 7, 0, 0); settle();
        chk("mov_r0_unprotected", int'(rf[0][0]), 8'h55);
        chk("mov_r0_protected", int'(rf[1][0]), 8'hAA);
        chk("mov_r0_protected_result", int'(result[1]), 8'h55);

        // op_valid held high: accepts exactly every fourth cycle
        @(posedge clk); #1;
        op_valid = 1'b1;
        acc = 12'h000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            acc[k] = op_ready[0];
            @(posedge clk); #1;
            op_code = 3'($urandom_range(0, 7));
            op_src1 = 4'($urandom_range(0, 15));
            op_src2 = 4'($urandom_range(0, 15));
            op_dst  = 4'($urandom_range(1, 15));
        end
        op_valid = 1'b0;
        chk("b2b_accept_pattern", int'(acc), 12'h111);
        settle();

        // Reset during EXEC of an ADD abandons it
        preload(9, 8'h3C);
        issue(1, 1, 2, 9);
        @(posedge clk); #1;
        Reset = 1'b1;
        @(negedge clk);
        chk("exec_reset_write", int'(wr[0]), 0);
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", int'(op_ready[0]), 1);
        chk("post_reset_result", int'(result[0]), 0);
        chk("post_reset_carry", int'(carry[0]), 0);
        chk("post_reset_destin", int'(dst[0]), 0);
        chk("post_reset_datain", int'(din[0]), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("exec_reset_r9_kept", int'(rf[0][9]), 8'h3C);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            Reset    = ($urandom_range(0, 63) == 0);
            op_valid = ($urandom_range(0, 3) != 0);
            op_code  = 3'($urandom_range(0, 7));
            op_src1  = 4'($urandom_range(0, 15));
            op_src2  = 4'($urandom_range(0, 15));
            op_dst   = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        Reset = 1'b0;
        op_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 16; r++) chk("final_regfile", int'(rf[i][r]), int'(mrf[i][r]));
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
